trail_collision_reader: RTL and testbench
=========================================

Name: trail_collision_reader

Overview:
- Read-side counterpart to the trail writer. Once per game frame it reads the trail occupancy grid at the blue and red bike head cells and flags collisions.
- Grid codes: 0 = empty, 1 = B_HORIZ, 2 = B_VERT, 3 = R_HORIZ, 4 = R_VERT, 5 = CORNER.
- Sits between the bike position logic, the trail grid RAM read port and the game-state FSM, which consumes the sticky collision flags to end a round.

Parameters:
- GRID_W, 112, grid width in cells (valid X is 0..GRID_W-1).
- GRID_H, 112, grid height in cells (valid Y is 0..GRID_H-1).
- ADDR_W, 14, grid address width; must satisfy GRID_W*GRID_H <= 2^ADDR_W.
- PLAY_STATE, 3'b010, Game_State encoding for active play.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  frame tick (~60 Hz), synchronous to Clk, level signal.
- Game_State  in  3  current game state.
- Blue_X, Blue_Y, Red_X, Red_Y  in  8 each  bike head cell coordinates, stable between frame ticks.
- grid_addr  out  ADDR_W  grid RAM read address.
- grid_re  out  1  grid read enable.
- grid_data  in  3  grid RAM read data, valid exactly 1 Clk after the address and enable are presented.
- collision_blue  out  1  sticky: blue crashed.
- collision_red  out  1  sticky: red crashed.
- check_done  out  1  one-cycle pulse when a frame check completes.

Behaviour:
- Clocking and reset: single Clk; Reset is synchronous, active-high.
- Reset values: state=IDLE, grid_addr=0, grid_re=0, collision_blue=0, collision_red=0, check_done=0, armed=0, frame_clk_d=0.
- Frame tick: frame_clk_d registers frame_clk. tick = frame_clk & ~frame_clk_d, i.e. a rising edge, one cycle wide.
- Not in play (Game_State != PLAY_STATE): behaves like Reset, except frame_clk_d still tracks frame_clk. Clears flags, sets armed=0, forces state to IDLE. This applies in any state, so it aborts an in-flight check.
- Arming: the first tick after entering play only sets armed=1 and performs no check. This skips the spawn frame.
- In-bounds test: bike in-bounds iff X < GRID_W and Y < GRID_H, unsigned 8-bit compare.
- Address: Y*GRID_W + X, computed in ADDR_W bits. Only used when in-bounds, so no overflow occurs.
- FSM states and transitions:
  - IDLE: on tick with armed=1, latch all four coordinates into local registers and go to RD_B.
  - RD_B: grid_addr = blue address and grid_re = 1 if blue is in-bounds; otherwise grid_addr = 0 and grid_re = 0. Go to RD_R.
  - RD_R: same for red. Capture grid_data as blue_code; force blue_code = 0 if blue was out of bounds. Go to CAP_R.
  - CAP_R: grid_re = 0. Capture red_code the same way. Go to EVAL.
  - EVAL: compute hit_b and hit_r (below). collision_blue |= hit_b; collision_red |= hit_r. check_done = 1 for this cycle only. Go to IDLE.
- Collision rules:
  - hit_b = blue out of bounds OR blue_code != 0 OR head_on.
  - hit_r = red out of bounds OR red_code != 0 OR head_on.
  - head_on = latched Blue_X==Red_X AND Blue_Y==Red_Y, and both bikes in-bounds.
  - Any nonzero code counts, including the bike's own trail and CORNER. Codes 6 and 7 also count as a hit.
- Latency: tick to check_done = 4 Clk cycles (RD_B, RD_R, CAP_R, EVAL). A flag changes in the same cycle check_done is high.
- Simultaneous crash: both flags set in the same EVAL cycle; no priority between bikes.
- Stickiness: flags never clear while Game_State == PLAY_STATE and Reset = 0. Checks continue after a crash, and flags only accumulate.
- Tick during RD_B..EVAL: ignored and not queued (frame period far exceeds 4 cycles).
- Coordinates changing mid-check: the latched copies are used.
- grid_re is high only in RD_B or RD_R, and only for an in-bounds bike. Outside those states grid_addr returns to 0.

Test Plan:
- Arming: Reset, Game_State=3'b010, empty grid, Blue=(10,10), Red=(50,50). First tick gives no check_done and no reads. Second tick gives grid_re with grid_addr=1130, then grid_addr=5650. check_done pulses exactly 4 cycles after the tick. Both flags stay 0.
- Trail hit: grid model returns 3 at address 1130, Blue=(10,10). After EVAL collision_blue=1 and collision_red=0. The flag stays 1 across 3 further empty-grid ticks.
- Wall: Red_X=112, Red_Y=20. No read is issued for red (grid_re=0 in RD_R). collision_red=1. Same result for Red_Y=255.
- Head-on: Blue=Red=(30,40), grid empty. Both flags set in the same cycle as check_done.
- Abort: Game_State leaves 3'b010 in cycle RD_R. Next cycle state=IDLE, grid_re=0, flags=0, and no check_done. On return to play, the first tick only re-arms.
- Mid-check tick and reset: a second frame_clk rising edge during CAP_R produces exactly one check_done. Reset asserted during EVAL of a hitting check gives flags=0 the next cycle.

Source files
------------

// File: rtl/trail_collision_reader.sv
// Per-frame trail collision check: reads the occupancy grid at both bike heads
// and accumulates sticky collision flags for the game-state FSM.
module trail_collision_reader #(
  parameter int unsigned GRID_W     = 112,
  parameter int unsigned GRID_H     = 112,
  parameter int unsigned ADDR_W     = 14,
  parameter logic [2:0]  PLAY_STATE = 3'b010
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [2:0]        Game_State,
  input  logic [7:0]        Blue_X,
  input  logic [7:0]        Blue_Y,
  input  logic [7:0]        Red_X,
  input  logic [7:0]        Red_Y,
  output logic [ADDR_W-1:0] grid_addr,
  output logic              grid_re,
  input  logic [2:0]        grid_data,
  output logic              collision_blue,
  output logic              collision_red,
  output logic              check_done
);

  typedef enum logic [2:0] {IDLE, RD_B, RD_R, CAP_R, EVAL} state_t;

  state_t            state, state_nx;
  logic              frame_clk_d, armed, tick, play;
  logic [7:0]        bx, by, rx, ry;
  logic [2:0]        blue_code, red_code;
  logic              flag_b, flag_r;
  logic              in_b, in_r, head_on, hit_b, hit_r;
  logic [ADDR_W-1:0] addr_b, addr_r;

  assign tick = frame_clk & ~frame_clk_d;
  assign play = (Game_State == PLAY_STATE);

  assign in_b    = (32'(bx) < GRID_W) && (32'(by) < GRID_H);
  assign in_r    = (32'(rx) < GRID_W) && (32'(ry) < GRID_H);
  assign addr_b  = ADDR_W'(by) * ADDR_W'(GRID_W) + ADDR_W'(bx);
  assign addr_r  = ADDR_W'(ry) * ADDR_W'(GRID_W) + ADDR_W'(rx);
  assign head_on = in_b && in_r && (bx == rx) && (by == ry);
  assign hit_b   = ~in_b | (blue_code != 3'd0) | head_on;
  assign hit_r   = ~in_r | (red_code != 3'd0) | head_on;

  // EVAL hits are ORed in combinationally so the flags rise with check_done;
  // the registered copy holds them from the following cycle on.
  assign collision_blue = flag_b | ((state == EVAL) & hit_b);
  assign collision_red  = flag_r | ((state == EVAL) & hit_r);

  always_ff @(posedge Clk) begin
    if (Reset) frame_clk_d <= 1'b0;
    else       frame_clk_d <= frame_clk;
  end

  always_ff @(posedge Clk) begin
    if (Reset || !play) begin
      state     <= IDLE;
      armed     <= 1'b0;
      flag_b    <= 1'b0;
      flag_r    <= 1'b0;
      blue_code <= '0;
      red_code  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && tick) begin
        armed <= 1'b1;
        if (armed) begin
          bx <= Blue_X;
          by <= Blue_Y;
          rx <= Red_X;
          ry <= Red_Y;
        end
      end
      if (state == RD_R)  blue_code <= in_b ? grid_data : 3'd0;
      if (state == CAP_R) red_code  <= in_r ? grid_data : 3'd0;
      if (state == EVAL) begin
        flag_b <= flag_b | hit_b;
        flag_r <= flag_r | hit_r;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    grid_addr  = '0;
    grid_re    = 1'b0;
    check_done = 1'b0;
    unique case (state)
      IDLE: if (tick && armed) state_nx = RD_B;
      RD_B: begin
        if (in_b) begin
          grid_addr = addr_b;
          grid_re   = 1'b1;
        end
        state_nx = RD_R;
      end
      RD_R: begin
        if (in_r) begin
          grid_addr = addr_r;
          grid_re   = 1'b1;
        end
        state_nx = CAP_R;
      end
      CAP_R: state_nx = EVAL;
      EVAL: begin
        check_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trail_collision_reader.sv
// Bench for trail_collision_reader: directed frames plus randomized frames
// checked against a rule-level model of the collision check.
module tb_trail_collision_reader;

  localparam logic [2:0] PLAY = 3'b010;
  localparam int GW = 112;
  localparam int GH = 112;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk;
  logic [2:0]  Game_State;
  logic [7:0]  Blue_X, Blue_Y, Red_X, Red_Y;
  logic [13:0] grid_addr;
  logic        grid_re;
  logic [2:0]  grid_data = 3'd0;
  logic        collision_blue, collision_red, check_done;

  logic [2:0]  grid_mem [0:GW*GH-1];

  int vectors = 0;
  int errors  = 0;
  bit m_cb, m_cr, m_armed;

  trail_collision_reader #(
    .GRID_W(112), .GRID_H(112), .ADDR_W(14), .PLAY_STATE(3'b010)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
    .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
    .grid_addr(grid_addr), .grid_re(grid_re), .grid_data(grid_data),
    .collision_blue(collision_blue), .collision_red(collision_red),
    .check_done(check_done)
  );

  always #10 Clk = ~Clk;

  // Synchronous-read RAM: data appears one Clk after address/enable.
  always @(posedge Clk)
    if (grid_re && 32'(grid_addr) < GW*GH) grid_data <= grid_mem[grid_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_grid();
    for (int i = 0; i < GW*GH; i++) grid_mem[i] = 3'd0;
  endtask

  task automatic restart();
    @(posedge Clk); #1 Game_State = 3'b001;
    @(posedge Clk); #1 Game_State = PLAY;
    m_cb = 0; m_cr = 0; m_armed = 0;
    @(negedge Clk);
    chk("restart_blue", 32'(collision_blue), 32'(0));
    chk("restart_red", 32'(collision_red), 32'(0));
  endtask

  // One frame tick; the model predicts reads, check_done timing and flags.
  task automatic frame(input int bx, input int by, input int rx, input int ry,
                       input bit retick, input bit abort, input bit rst);
    bit do_chk, inb_b, inb_r, head, hb, hr;
    int ab, ar;
    logic [2:0] code_b, code_r;
    do_chk = m_armed;
    inb_b  = (bx < GW) && (by < GH);
    inb_r  = (rx < GW) && (ry < GH);
    ab     = by * GW + bx;
    ar     = ry * GW + rx;
    code_b = inb_b ? grid_mem[ab] : 3'd0;
    code_r = inb_r ? grid_mem[ar] : 3'd0;
    head   = inb_b && inb_r && (bx == rx) && (by == ry);
    hb     = !inb_b || (code_b != 0) || head;
    hr     = !inb_r || (code_r != 0) || head;
    @(posedge Clk); #1;
    Blue_X = 8'(bx); Blue_Y = 8'(by); Red_X = 8'(rx); Red_Y = 8'(ry);
    frame_clk = 1'b1;
    m_armed = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (abort && k == 3) begin m_cb = 0; m_cr = 0; m_armed = 0; end
      if (k == 4 && do_chk && !abort) begin m_cb |= hb; m_cr |= hr; end
      if (rst && k == 5) begin m_cb = 0; m_cr = 0; m_armed = 0; end
      chk("check_done", 32'(check_done), 32'(k == 4 && do_chk && !abort));
      chk("collision_blue", 32'(collision_blue), 32'(m_cb));
      chk("collision_red", 32'(collision_red), 32'(m_cr));
      if (do_chk && k == 1) begin
        chk("re_blue", 32'(grid_re), 32'(inb_b));
        chk("addr_blue", 32'(grid_addr), inb_b ? 32'(ab) : 32'(0));
      end else if (do_chk && k == 2) begin
        chk("re_red", 32'(grid_re), 32'(inb_r));
        chk("addr_red", 32'(grid_addr), inb_r ? 32'(ar) : 32'(0));
      end else begin
        chk("re_quiet", 32'(grid_re), 32'(0));
        chk("addr_quiet", 32'(grid_addr), 32'(0));
      end
      if (k == 1) begin
        frame_clk = 1'b0;
        Blue_X = 8'($urandom); Blue_Y = 8'($urandom);
        Red_X  = 8'($urandom); Red_Y  = 8'($urandom);
      end
      if (retick && k == 3) frame_clk = 1'b1;
      if (abort && k == 2) Game_State = 3'b000;
      if (rst && k == 4) Reset = 1'b1;
      if (rst && k == 5) Reset = 1'b0;
    end
    frame_clk  = 1'b0;
    Game_State = PLAY;
  endtask

  function automatic int rnd_coord();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 255;
    if (r == 1) return int'($urandom_range(112, 140));
    return int'($urandom_range(0, 111));
  endfunction

  initial begin
    int bx, by, rx, ry;
    clear_grid();
    Reset = 1'b1; frame_clk = 1'b0; Game_State = PLAY;
    Blue_X = '0; Blue_Y = '0; Red_X = '0; Red_Y = '0;
    m_cb = 0; m_cr = 0; m_armed = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_re", 32'(grid_re), 32'(0));
    chk("rst_addr", 32'(grid_addr), 32'(0));
    chk("rst_blue", 32'(collision_blue), 32'(0));
    chk("rst_red", 32'(collision_red), 32'(0));
    chk("rst_done", 32'(check_done), 32'(0));
    Reset = 1'b0;

    // Arming tick, then a clean check at addresses 1130 / 5650.
    frame(10, 10, 50, 50, 0, 0, 0);
    frame(10, 10, 50, 50, 0, 0, 0);

    // Red-trail code under blue's head; flag sticks over empty frames.
    grid_mem[1130] = 3'd3;
    frame(10, 10, 50, 50, 0, 0, 0);
    grid_mem[1130] = 3'd0;
    repeat (3) frame(10, 10, 50, 50, 0, 0, 0);

    // Walls.
    restart(); frame(10, 10, 50, 50, 0, 0, 0);
    frame(10, 10, 112, 20, 0, 0, 0);
    restart(); frame(10, 10, 50, 50, 0, 0, 0);
    frame(10, 10, 20, 255, 0, 0, 0);

    // Head-on.
    restart(); frame(10, 10, 50, 50, 0, 0, 0);
    frame(30, 40, 30, 40, 0, 0, 0);

    // Abort in RD_R, then re-arm and check.
    restart(); frame(10, 10, 50, 50, 0, 0, 0);
    grid_mem[5650] = 3'd5;
    frame(10, 10, 50, 50, 0, 1, 0);
    frame(10, 10, 50, 50, 0, 0, 0);
    frame(10, 10, 50, 50, 0, 0, 0);
    grid_mem[5650] = 3'd0;

    // Second rising edge during CAP_R, then reset during EVAL of a hit.
    restart(); frame(10, 10, 50, 50, 0, 0, 0);
    frame(10, 10, 50, 50, 1, 0, 0);
    grid_mem[1130] = 3'd7;
    frame(10, 10, 50, 50, 0, 0, 1);
    frame(10, 10, 50, 50, 0, 0, 0);
    frame(10, 10, 50, 50, 0, 0, 0);
    grid_mem[1130] = 3'd0;

    // Randomized rounds.
    for (int it = 0; it < 16; it++) begin
      restart();
      clear_grid();
      frame(rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), 0, 0, 0);
      for (int f = 0; f < 2; f++) begin
        bx = rnd_coord(); by = rnd_coord();
        rx = rnd_coord(); ry = rnd_coord();
        if ($urandom_range(0, 4) == 0) begin rx = bx; ry = by; end
        if (bx < GW && by < GH && $urandom_range(0, 1) == 1)
          grid_mem[by * GW + bx] = 3'($urandom_range(1, 7));
        if (rx < GW && ry < GH && $urandom_range(0, 1) == 1)
          grid_mem[ry * GW + rx] = 3'($urandom_range(1, 7));
        frame(bx, by, rx, ry, 0, 0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
